render_cmd_queue: RTL

- Avalon-MM slave that collects 48-bit sprite render commands from software and presents them FWFT to the display engine's instruction-fetch port.
- Commands are released to the consumer only in whole frames; a frame is terminated by a command whose magic byte [47:40] is 8'hFF (DO_RENDER). The consumer therefore never starts a half-written frame.
- Sits between the HPS bridge and vga_display (render_queue_dout / render_queue_pop_front).

---
 rtl/render_pkg.sv | 42 ++++
 rtl/cmd_fifo_mem.sv | 24 ++
 rtl/render_cmd_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
// Shared types and constants for the render command queue and the vga_display consumer.
package render_pkg;

  typedef struct packed {
    logic [7:0]  magic;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  flags;
  } render_cmd_t;

  localparam logic [7:0] MAGIC_DO_RENDER = 8'hFF;

  localparam logic [7:0] SPRITE_MAGIC_NOP       = 8'h00;
  localparam logic [7:0] SPRITE_MAGIC_SPRITE    = 8'h01;
  localparam logic [7:0] SPRITE_MAGIC_CLEAR     = 8'h02;
  localparam logic [7:0] SPRITE_MAGIC_DO_RENDER = MAGIC_DO_RENDER;

  localparam logic [1:0] REG_CMD_HI  = 2'd0;
  localparam logic [1:0] REG_CMD_MID = 2'd1;
  localparam logic [1:0] REG_CMD_LO  = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int STATUS_OVERFLOW   = 15;
  localparam int STATUS_IRQ        = 14;
  localparam int STATUS_FRAMES_LSB = 8;
  localparam int STATUS_COUNT_LSB  = 0;

  function automatic logic [15:0] pack_status(input logic       ovf,
                                              input logic       irq_bit,
                                              input logic [5:0] frames,
                                              input logic [7:0] count);
    logic [15:0] s;
    s = '0;
    s[STATUS_OVERFLOW]            = ovf;
    s[STATUS_IRQ]                 = irq_bit;
    s[STATUS_FRAMES_LSB +: 6]     = frames;
    s[STATUS_COUNT_LSB +: 8]      = count;
    return s;
  endfunction

endpackage

// File: rtl/cmd_fifo_mem.sv
// DEPTH x CMD_W command storage: synchronous write, asynchronous read (MLAB-friendly, no reset).
module cmd_fifo_mem
  import render_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CMD_W = 48
) (
  input  logic                     clk50,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [CMD_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [CMD_W-1:0]         rdata
);

  logic [CMD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk50) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/render_cmd_queue.sv
// Avalon-MM render command queue releasing whole frames FWFT to the display engine.
// Optional frame-consumed interrupt: define RENDER_CMD_QUEUE_IRQ_EN.
module render_cmd_queue
  import render_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CMD_W = 48
) (
  input  logic             clk50,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic             write,
  input  logic             read,
  input  logic [1:0]       address,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  output logic [CMD_W-1:0] render_queue_dout,
  output logic             render_queue_valid,
  input  logic             render_queue_pop_front
`ifdef RENDER_CMD_QUEUE_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]       wr_ptr, rd_ptr, used_cnt;
  logic [7:0]          count8;
  logic [CMD_W-1:16]   staging_hi;
  logic [5:0]          frames_pending;
  logic                overflow;
  logic                irq_bit;
  logic [15:0]         status_word;

  logic                wr_sel, push_req, flush, status_rd;
  logic                full, empty;
  logic                push_ff, head_ff, fp_sat;
  logic                push_drop, push_ok, pop_ok, ovf_set;
  render_cmd_t         push_cmd;
  logic [CMD_W-1:0]    head_raw;

  assign wr_sel    = chipselect && write;
  assign push_req  = wr_sel && (address == REG_CMD_LO);
  assign flush     = wr_sel && (address == REG_CTRL);
  assign status_rd = chipselect && read && (address == REG_STATUS);

  // The low word goes straight into the pushed command; only the upper words need holding.
  assign push_cmd = {staging_hi, writedata};
  assign push_ff  = (push_cmd.magic == MAGIC_DO_RENDER);
  assign head_ff  = (head_raw[CMD_W-1 -: 8] == MAGIC_DO_RENDER);

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign used_cnt = wr_ptr - rd_ptr;
  assign count8   = 8'(used_cnt);

  assign render_queue_valid = (frames_pending != 6'd0) && !empty;
  assign render_queue_dout  = head_raw;

  // Full is judged on the pre-pop state; a frame count of 63 only blocks a push
  // that would actually take it past 63.
  assign pop_ok    = render_queue_pop_front && render_queue_valid && !flush;
  assign fp_sat    = push_ff && (frames_pending == 6'd63) && !(pop_ok && head_ff);
  assign push_drop = push_req && (full || fp_sat);
  assign push_ok   = push_req && !push_drop && !flush;
  assign ovf_set   = push_drop && !flush;

  cmd_fifo_mem #(
    .DEPTH(DEPTH),
    .CMD_W(CMD_W)
  ) u_mem (
    .clk50 (clk50),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (push_cmd),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head_raw)
  );

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      frames_pending <= '0;
      overflow       <= 1'b0;
      staging_hi     <= '0;
    end else if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      frames_pending <= '0;
      overflow       <= 1'b0;
      staging_hi     <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok && push_ff, pop_ok && head_ff})
        2'b10:   frames_pending <= frames_pending + 6'd1;
        2'b01:   frames_pending <= frames_pending - 6'd1;
        default: frames_pending <= frames_pending;
      endcase
      if (ovf_set)        overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
      if (wr_sel && (address == REG_CMD_HI))  staging_hi[CMD_W-1:32] <= writedata;
      if (wr_sel && (address == REG_CMD_MID)) staging_hi[31:16]      <= writedata;
    end
  end

`ifdef RENDER_CMD_QUEUE_IRQ_EN
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (pop_ok && head_ff) begin
      irq <= 1'b1;
    end else if (status_rd) begin
      irq <= 1'b0;
    end
  end
  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
`endif

  assign status_word = pack_status(overflow, irq_bit, frames_pending, count8);

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (chipselect && read) begin
      readdata <= (address == REG_STATUS) ? status_word : 16'h0000;
    end
  end

endmodule
